// File: rtl/gpio_debounce.sv
// One GPIO input pin: synchronizer, tick-driven debounce counter, stable value and edge strobe.
module gpio_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_WIDTH    = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                pad_in,
    input  logic                tick,
    input  logic                db_en,
    input  logic [DB_WIDTH-1:0] db_thresh,
    output logic                r_data,
    output logic                edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_val;
    logic                   stable_q, stable_d;
    logic                   prev_q, prev_d;
    logic                   edge_q, edge_d;
    logic [DB_WIDTH-1:0]    dcnt_q, dcnt_d;
    logic [DB_WIDTH-1:0]    thr_m1;

    assign sync_val = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
        // A zero threshold behaves like one: accept on the first mismatching tick.
        thr_m1   = (db_thresh == '0) ? '0 : db_thresh - DB_WIDTH'(1);
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        if (!db_en) begin
            stable_d = sync_val;
            dcnt_d   = '0;
        end else if (tick) begin
            if (sync_val == stable_q) begin
                dcnt_d = '0;
            end else if (dcnt_q >= thr_m1) begin
                stable_d = sync_val;
                dcnt_d   = '0;
            end else if (dcnt_q != '1) begin
                dcnt_d = dcnt_q + DB_WIDTH'(1);
            end
        end
        prev_d = stable_q;
        edge_d = stable_q ^ prev_q;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            edge_q   <= 1'b0;
            dcnt_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            edge_q   <= edge_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign r_data     = stable_q;
    assign edge_pulse = edge_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Pad-side GPIO glue: registered tri-state drive plus conditioned, debounced pad inputs.
module gpio_pad_ctrl #(
    parameter int unsigned NUM_PINS    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_WIDTH    = 4,
    parameter int unsigned PRESCALE_W  = 8
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NUM_PINS-1:0]   w_data,
    input  logic [NUM_PINS-1:0]   en_data,
    output logic [NUM_PINS-1:0]   r_data,
    output logic [NUM_PINS-1:0]   edge_pulse,
    input  logic [NUM_PINS-1:0]   pad_in,
    output logic [NUM_PINS-1:0]   pad_out,
    output logic [NUM_PINS-1:0]   pad_oe,
    input  logic [NUM_PINS-1:0]   db_en,
    input  logic [DB_WIDTH-1:0]   db_thresh,
    input  logic [PRESCALE_W-1:0] prescale
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  tick;
    logic [NUM_PINS-1:0]   pad_out_q, pad_out_d;
    logic [NUM_PINS-1:0]   pad_oe_q, pad_oe_d;

    always_comb begin
        // >= so that lowering prescale below the running count wraps at once.
        tick      = (cnt_q >= prescale);
        cnt_d     = tick ? '0 : cnt_q + PRESCALE_W'(1);
        pad_out_d = w_data;
        pad_oe_d  = en_data;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q     <= '0;
            pad_out_q <= '0;
            pad_oe_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pad_out_q <= pad_out_d;
            pad_oe_q  <= pad_oe_d;
        end
    end

    assign pad_out = pad_out_q;
    assign pad_oe  = pad_oe_q;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_WIDTH    (DB_WIDTH)
        ) u_debounce (
            .CLK        (CLK),
            .nRST       (nRST),
            .pad_in     (pad_in[i]),
            .tick       (tick),
            .db_en      (db_en[i]),
            .db_thresh  (db_thresh),
            .r_data     (r_data[i]),
            .edge_pulse (edge_pulse[i])
        );
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: cycle model from the behavioural rules plus directed literal checks.
module tb_gpio_pad_ctrl;

    localparam int NP = 8;
    localparam int SS = 2;
    localparam int DW = 4;
    localparam int PW = 8;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk;
    logic          nrst;
    logic [NP-1:0] w_data, en_data, pad_in, db_en;
    logic [NP-1:0] r_data, edge_pulse, pad_out, pad_oe;
    logic [DW-1:0] db_thresh;
    logic [PW-1:0] prescale;

    int n_pass  = 0;
    int n_total = 0;

    gpio_pad_ctrl #(
        .NUM_PINS    (NP),
        .SYNC_STAGES (SS),
        .DB_WIDTH    (DW),
        .PRESCALE_W  (PW)
    ) dut (
        .CLK        (clk),
        .nRST       (nrst),
        .w_data     (w_data),
        .en_data    (en_data),
        .r_data     (r_data),
        .edge_pulse (edge_pulse),
        .pad_in     (pad_in),
        .pad_out    (pad_out),
        .pad_oe     (pad_oe),
        .db_en      (db_en),
        .db_thresh  (db_thresh),
        .prescale   (prescale)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: pad history delayed SS cycles, a tick counter, and per-pin accepted value/run length.
    logic [NP-1:0] m_hist [SS];
    int            m_cnt;
    int            m_run [NP];
    logic [NP-1:0] m_stable, m_last, m_edge, m_pout, m_poe;

    always @(posedge clk) begin
        logic          tk;
        logic [NP-1:0] seen;
        int            thr;
        if (!nrst) begin
            for (int k = 0; k < SS; k++) m_hist[k] = '0;
            for (int p = 0; p < NP; p++) m_run[p] = 0;
            m_cnt = 0;
            m_stable = '0; m_last = '0; m_edge = '0; m_pout = '0; m_poe = '0;
        end else begin
            m_pout = w_data;
            m_poe  = en_data;
            tk     = (m_cnt >= int'(prescale));
            m_cnt  = tk ? 0 : m_cnt + 1;
            seen   = m_hist[SS-1];
            thr    = (db_thresh == 0) ? 1 : int'(db_thresh);
            m_edge = m_stable ^ m_last;
            m_last = m_stable;
            for (int p = 0; p < NP; p++) begin
                if (!db_en[p]) begin
                    m_stable[p] = seen[p];
                    m_run[p] = 0;
                end else if (tk) begin
                    if (seen[p] == m_stable[p]) m_run[p] = 0;
                    else if (m_run[p] + 1 >= thr) begin
                        m_stable[p] = seen[p];
                        m_run[p] = 0;
                    end else if (m_run[p] < DMAX) m_run[p] = m_run[p] + 1;
                end
            end
            for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pad_in;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model pad_out", 32'(pad_out), 32'(m_pout));
        chk("model pad_oe", 32'(pad_oe), 32'(m_poe));
        chk("model r_data", 32'(r_data), 32'(m_stable));
        chk("model edge_pulse", 32'(edge_pulse), 32'(m_edge));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [NP-1:0] vec [6];

    initial begin
        nrst = 1'b0; w_data = 8'hFF; en_data = 8'hFF; pad_in = 8'hFF;
        db_en = '0; db_thresh = '0; prescale = '0;
        step(3);
        chk("reset pad_out", 32'(pad_out), 32'h0);
        chk("reset pad_oe", 32'(pad_oe), 32'h0);
        chk("reset r_data", 32'(r_data), 32'h0);
        chk("reset edge_pulse", 32'(edge_pulse), 32'h0);
        nrst = 1'b1; pad_in = '0;
        step(1);
        chk("release pad_out", 32'(pad_out), 32'hFF);
        chk("release pad_oe", 32'(pad_oe), 32'hFF);
        w_data = 8'h3C; en_data = 8'h0F;
        step(1);
        chk("drive pad_out", 32'(pad_out), 32'h3C);
        chk("drive pad_oe", 32'(pad_oe), 32'h0F);
        step(3);

        // Bypass latency
        pad_in = 8'h01;
        step(2); chk("bypass r0 early", 32'(r_data[0]), 32'h0);
        step(1); chk("bypass r0 edge3", 32'(r_data[0]), 32'h1);
        chk("bypass pulse edge3", 32'(edge_pulse[0]), 32'h0);
        step(1); chk("bypass pulse edge4", 32'(edge_pulse[0]), 32'h1);
        step(1); chk("bypass pulse edge5", 32'(edge_pulse[0]), 32'h0);
        pad_in = '0;
        step(6);

        // Debounce accept, thr=4
        db_en = 8'hFF; db_thresh = 4'd4;
        pad_in = 8'h08;
        step(5); chk("db r3 edge5", 32'(r_data[3]), 32'h0);
        step(1); chk("db r3 edge6", 32'(r_data[3]), 32'h1);
        step(1); chk("db pulse3", 32'(edge_pulse[3]), 32'h1);
        pad_in = '0;
        step(8); chk("db r3 back", 32'(r_data[3]), 32'h0);
        step(2);

        // Glitch of thr-1 samples is discarded
        pad_in = 8'h08;
        step(3);
        pad_in = '0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            chk("glitch r3", 32'(r_data[3]), 32'h0);
            chk("glitch pulse3", 32'(edge_pulse[3]), 32'h0);
        end

        // Lowering the threshold below the running count accepts on the next tick
        db_thresh = 4'd15; pad_in = 8'h08;
        step(6); chk("lower r3 before", 32'(r_data[3]), 32'h0);
        db_thresh = 4'd2;
        step(1); chk("lower r3 after", 32'(r_data[3]), 32'h1);
        pad_in = '0; db_thresh = 4'd4;
        step(8);

        // Prescaler from a known phase, thr=2 then thr=0
        nrst = 1'b0; prescale = 8'd3; db_thresh = 4'd2;
        step(1); chk("pre reset r_data", 32'(r_data), 32'h0);
        nrst = 1'b1; pad_in = 8'h20;
        step(7); chk("pre r5 edge7", 32'(r_data[5]), 32'h0);
        step(1); chk("pre r5 edge8", 32'(r_data[5]), 32'h1);
        db_thresh = 4'd0; pad_in = '0;
        step(3); chk("thr0 r5 edge11", 32'(r_data[5]), 32'h1);
        step(1); chk("thr0 r5 edge12", 32'(r_data[5]), 32'h0);
        step(4);

        // Reset mid-count needs a full count again
        prescale = '0; db_thresh = 4'd4; pad_in = 8'h08;
        step(4);
        nrst = 1'b0;
        step(1);
        chk("midrst r_data", 32'(r_data), 32'h0);
        chk("midrst pad_oe", 32'(pad_oe), 32'h0);
        nrst = 1'b1;
        step(5); chk("midrst r3 early", 32'(r_data[3]), 32'h0);
        step(1); chk("midrst r3 accept", 32'(r_data[3]), 32'h1);

        // Mixed bypass/debounce pins, model-checked
        db_en = 8'h0F; db_thresh = 4'd3; prescale = 8'd1;
        vec[0] = 8'hA5; vec[1] = 8'h5A; vec[2] = 8'hFF;
        vec[3] = 8'h00; vec[4] = 8'hC3; vec[5] = 8'h3C;
        for (int v = 0; v < 6; v++) begin
            pad_in = vec[v]; w_data = ~vec[v]; en_data = vec[v];
            step(3 + v * 2);
        end
        pad_in = '0;
        step(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
